// File: rtl/cell_scheduler.sv
// Cell scheduler: issues operand cells to a fixed-latency cell processor and
// returns its pixels through a credit-limited FIFO with valid/ready handshake.
module cell_scheduler #(
  parameter int CELL_DEPTH   = 72,
  parameter int OPCODE_WIDTH = 4,
  parameter int USER_WIDTH   = 8,
  parameter int PIXEL_WIDTH  = 8,
  parameter int PROC_LATENCY = 2,
  parameter int NUM_CELLS    = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [OPCODE_WIDTH-1:0] cfg_opcode,
  input  logic [USER_WIDTH-1:0]   cfg_user,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [CELL_DEPTH-1:0]   src_cellA,
  input  logic [CELL_DEPTH-1:0]   src_cellB,
  output logic [CELL_DEPTH-1:0]   proc_cellA,
  output logic [CELL_DEPTH-1:0]   proc_cellB,
  output logic [USER_WIDTH-1:0]   proc_userInput,
  output logic [OPCODE_WIDTH-1:0] proc_opcode,
  output logic                    proc_valid,
  input  logic [PIXEL_WIDTH-1:0]  proc_pixel,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [PIXEL_WIDTH-1:0]  pix_data,
  output logic                    pix_last,
  output logic                    busy,
  output logic                    done
);

  localparam int FIFO_DEPTH = PROC_LATENCY + 2;
  localparam int CNT_W      = $clog2(NUM_CELLS + 1);
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  stateT                   stateQ;
  logic [CNT_W-1:0]        issued;
  logic [CNT_W-1:0]        accepted;
  logic [OCC_W-1:0]        inFlight;
  logic [OCC_W-1:0]        fifoCount;
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W-1:0]        rdPtr;
  logic [PROC_LATENCY-1:0] validSr;
  logic [PIXEL_WIDTH-1:0]  mem [FIFO_DEPTH];

  logic xfer;
  logic push;
  logic pop;

  // Credit counts every cell between issue and FIFO write, so the FIFO can never overflow.
  always_comb begin
    src_ready = (stateQ == RUN) && (issued < CNT_W'(NUM_CELLS)) &&
                (({1'b0, inFlight} + {1'b0, fifoCount}) < (OCC_W + 1)'(FIFO_DEPTH));
    pix_valid = (fifoCount != '0);
    pix_data  = pix_valid ? mem[rdPtr] : '0;
    pix_last  = pix_valid && (accepted == LAST_CELL);
    xfer      = src_valid && src_ready;
    push      = validSr[PROC_LATENCY-1];
    pop       = pix_valid && pix_ready;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= proc_pixel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ         <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      proc_cellA     <= '0;
      proc_cellB     <= '0;
      proc_userInput <= '0;
      proc_opcode    <= '0;
      proc_valid     <= 1'b0;
      validSr        <= '0;
      issued         <= '0;
      accepted       <= '0;
      inFlight       <= '0;
      fifoCount      <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
    end else if (abort && (stateQ != DONE)) begin
      stateQ     <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      proc_valid <= 1'b0;
      validSr    <= '0;
      issued     <= '0;
      accepted   <= '0;
      inFlight   <= '0;
      fifoCount  <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
    end else begin
      proc_valid <= xfer;
      if (xfer) begin
        proc_cellA <= src_cellA;
        proc_cellB <= src_cellB;
        issued     <= issued + CNT_W'(1);
      end

      validSr[0] <= proc_valid;
      for (int unsigned i = 1; i < PROC_LATENCY; i++) validSr[i] <= validSr[i-1];

      if (push) wrPtr <= (wrPtr == PTR_LAST) ? '0 : wrPtr + PTR_W'(1);
      if (pop) begin
        rdPtr    <= (rdPtr == PTR_LAST) ? '0 : rdPtr + PTR_W'(1);
        accepted <= accepted + CNT_W'(1);
      end

      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + OCC_W'(1);
        2'b01:   fifoCount <= fifoCount - OCC_W'(1);
        default: fifoCount <= fifoCount;
      endcase

      case ({xfer, push})
        2'b10:   inFlight <= inFlight + OCC_W'(1);
        2'b01:   inFlight <= inFlight - OCC_W'(1);
        default: inFlight <= inFlight;
      endcase

      case (stateQ)
        IDLE: begin
          if (start) begin
            proc_opcode    <= cfg_opcode;
            proc_userInput <= cfg_user;
            issued         <= '0;
            accepted       <= '0;
            stateQ         <= RUN;
            busy           <= 1'b1;
          end
        end
        RUN: begin
          if (xfer && (issued == LAST_CELL)) stateQ <= DRAIN;
        end
        DRAIN: begin
          if (pop && (accepted == LAST_CELL)) begin
            stateQ <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          stateQ <= IDLE;
          done   <= 1'b0;
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_scheduler.sv
// Directed bench for cell_scheduler with a two-stage behavioural cell processor
// (pixel = cellA[7:0] + cellB[7:0]).
module tb_cell_scheduler;
  localparam int CD = 16;
  localparam int OW = 4;
  localparam int UW = 8;
  localparam int PW = 8;
  localparam int PL = 2;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [OW-1:0] cfg_opcode;
  logic [UW-1:0] cfg_user;
  logic          src_valid, src_ready;
  logic [CD-1:0] src_cellA, src_cellB, proc_cellA, proc_cellB;
  logic [UW-1:0] proc_userInput;
  logic [OW-1:0] proc_opcode;
  logic          proc_valid;
  logic [PW-1:0] proc_pixel;
  logic          pix_valid, pix_ready, pix_last, busy, done;
  logic [PW-1:0] pix_data;

  always #5 clk = ~clk;

  cell_scheduler #(
    .CELL_DEPTH(CD), .OPCODE_WIDTH(OW), .USER_WIDTH(UW),
    .PIXEL_WIDTH(PW), .PROC_LATENCY(PL), .NUM_CELLS(NC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_opcode(cfg_opcode), .cfg_user(cfg_user),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_cellA(src_cellA), .src_cellB(src_cellB),
    .proc_cellA(proc_cellA), .proc_cellB(proc_cellB),
    .proc_userInput(proc_userInput), .proc_opcode(proc_opcode),
    .proc_valid(proc_valid), .proc_pixel(proc_pixel),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  // Processor model: garbage when not issued, so mistimed captures show up.
  logic [PW-1:0] procPipe [PL];
  always @(posedge clk) begin
    procPipe[0] <= proc_valid ? (proc_cellA[7:0] + proc_cellB[7:0]) : 8'hEE;
    for (int i = 1; i < PL; i++) procPipe[i] <= procPipe[i-1];
  end
  assign proc_pixel = procPipe[PL-1];

  int errors = 0;
  int checks = 0;
  int txN, rxN, procCnt, doneCnt;
  logic [7:0]    rxData [16];
  logic          rxLast [16];
  logic [OW-1:0] frameOp;
  logic [7:0]    expPix [4] = '{8'h30, 8'h32, 8'h34, 8'h36};
  logic [3:0]    pat = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setCells();
    src_cellA = {8'hA0, 8'h10 + 8'(txN)};
    src_cellB = {8'hB0, 8'h20 + 8'(txN)};
  endtask

  task automatic resetLogs();
    txN = 0; rxN = 0; procCnt = 0; doneCnt = 0;
    for (int i = 0; i < 16; i++) begin rxData[i] = 8'h00; rxLast[i] = 1'b0; end
    setCells();
  endtask

  task automatic step();
    if (src_valid && src_ready) txN++;
    if (pix_valid && pix_ready) begin
      if (rxN < 16) begin rxData[rxN] = pix_data; rxLast[rxN] = pix_last; end
      rxN++;
    end
    if (proc_valid) begin
      procCnt++;
      check("procOpcode", 64'(proc_opcode), 64'(frameOp));
    end
    if (done) doneCnt++;
    @(posedge clk); #1;
    setCells();
  endtask

  task automatic startFrame(input logic [OW-1:0] op, input logic [UW-1:0] user);
    start = 1'b1; cfg_opcode = op; cfg_user = user; frameOp = op;
    step();
    start = 1'b0;
  endtask

  task automatic runUntilDone(input string tag, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) step();
    check(tag, 64'(done), 64'(1));
  endtask

  task automatic checkFrame(input string tag);
    check($sformatf("%s.count", tag), 64'(rxN), 64'(NC));
    for (int i = 0; i < NC; i++) begin
      check($sformatf("%s.pix%0d", tag, i), 64'(rxData[i]), 64'(expPix[i]));
      check($sformatf("%s.last%0d", tag, i), 64'(rxLast[i]), 64'(i == NC - 1));
    end
  endtask

  task automatic checkAllZero(input string tag);
    check($sformatf("%s.busy", tag), 64'(busy), 64'(0));
    check($sformatf("%s.done", tag), 64'(done), 64'(0));
    check($sformatf("%s.srcReady", tag), 64'(src_ready), 64'(0));
    check($sformatf("%s.procValid", tag), 64'(proc_valid), 64'(0));
    check($sformatf("%s.procOpcode", tag), 64'(proc_opcode), 64'(0));
    check($sformatf("%s.procUser", tag), 64'(proc_userInput), 64'(0));
    check($sformatf("%s.procCellA", tag), 64'(proc_cellA), 64'(0));
    check($sformatf("%s.procCellB", tag), 64'(proc_cellB), 64'(0));
    check($sformatf("%s.pixValid", tag), 64'(pix_valid), 64'(0));
    check($sformatf("%s.pixData", tag), 64'(pix_data), 64'(0));
    check($sformatf("%s.pixLast", tag), 64'(pix_last), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_opcode = '0; cfg_user = '0;
    src_valid = 1'b0; pix_ready = 1'b0; frameOp = '0;
    resetLogs();
    #3;
    checkAllZero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    check("idleBusy", 64'(busy), 64'(0));

    // Basic frame, full throughput
    resetLogs(); src_valid = 1'b1; pix_ready = 1'b1;
    startFrame(4'd3, 8'h5A);
    check("f1.busy", 64'(busy), 64'(1));
    check("f1.opcode", 64'(proc_opcode), 64'(3));
    check("f1.user", 64'(proc_userInput), 64'(8'h5A));
    check("f1.srcReady", 64'(src_ready), 64'(1));
    step();
    check("f1.procValid", 64'(proc_valid), 64'(1));
    check("f1.procCellA", 64'(proc_cellA), 64'(16'hA010));
    check("f1.procCellB", 64'(proc_cellB), 64'(16'hB020));
    step(); step();
    check("f1.pixValidEarly", 64'(pix_valid), 64'(0));
    step();
    check("f1.pixValidFirst", 64'(pix_valid), 64'(1));
    check("f1.pixDataFirst", 64'(pix_data), 64'(8'h30));
    check("f1.pixLastFirst", 64'(pix_last), 64'(0));
    step(); step(); step();
    check("f1.pixLast4", 64'(pix_last), 64'(1));
    check("f1.pixData4", 64'(pix_data), 64'(8'h36));
    step();
    check("f1.done", 64'(done), 64'(1));
    check("f1.busyDone", 64'(busy), 64'(0));
    step();
    check("f1.donePulse", 64'(done), 64'(0));
    check("f1.procCnt", 64'(procCnt), 64'(NC));
    checkFrame("f1");

    // Output stalled: credit stops the source after all cells issue
    resetLogs(); src_valid = 1'b1; pix_ready = 1'b0;
    startFrame(4'd3, 8'h11);
    repeat (7) step();
    check("f2.txN", 64'(txN), 64'(NC));
    check("f2.srcReady", 64'(src_ready), 64'(0));
    check("f2.pixValid", 64'(pix_valid), 64'(1));
    check("f2.headA", 64'(pix_data), 64'(8'h30));
    step();
    check("f2.headStable", 64'(pix_data), 64'(8'h30));
    check("f2.busy", 64'(busy), 64'(1));
    pix_ready = 1'b1;
    runUntilDone("f2.done", 20);
    checkFrame("f2");
    step();

    // Abort after two transfers, then a clean frame
    resetLogs(); src_valid = 1'b1; pix_ready = 1'b1;
    startFrame(4'd3, 8'h22);
    step(); step();
    check("f3.txN", 64'(txN), 64'(2));
    abort = 1'b1; src_valid = 1'b0;
    step();
    abort = 1'b0;
    check("f3.busy", 64'(busy), 64'(0));
    check("f3.pixValid", 64'(pix_valid), 64'(0));
    check("f3.srcReady", 64'(src_ready), 64'(0));
    repeat (6) step();
    check("f3.noDone", 64'(doneCnt), 64'(0));
    check("f3.noPix", 64'(rxN), 64'(0));
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("f3.abortWins", 64'(busy), 64'(0));
    resetLogs(); src_valid = 1'b1;
    startFrame(4'd3, 8'h22);
    runUntilDone("f3b.done", 20);
    checkFrame("f3b");
    step();

    // Start and cfg changes mid-frame are ignored
    resetLogs(); src_valid = 1'b1; pix_ready = 1'b1;
    startFrame(4'd3, 8'h5A);
    step();
    start = 1'b1; cfg_opcode = 4'd7; cfg_user = 8'hC3;
    step();
    start = 1'b0;
    check("f4.opcode", 64'(proc_opcode), 64'(3));
    check("f4.user", 64'(proc_userInput), 64'(8'h5A));
    runUntilDone("f4.done", 20);
    checkFrame("f4");
    step();

    // Asynchronous reset in DRAIN
    resetLogs(); src_valid = 1'b1; pix_ready = 1'b0;
    startFrame(4'd3, 8'h77);
    repeat (6) step();
    check("f5.preBusy", 64'(busy), 64'(1));
    check("f5.prePixValid", 64'(pix_valid), 64'(1));
    #3 rst = 1'b0;
    #1;
    checkAllZero("f5.async");
    #1 rst = 1'b1;
    step();
    check("f5.idleBusy", 64'(busy), 64'(0));
    check("f5.idleSrcReady", 64'(src_ready), 64'(0));
    step(); step();
    check("f5.needStart", 64'(busy), 64'(0));
    check("f5.noPix", 64'(pix_valid), 64'(0));

    // Bursty source with random back-pressure
    resetLogs(); src_valid = 1'b1; pix_ready = 1'b1;
    startFrame(4'd3, 8'h01);
    for (int i = 0; i < 80 && done !== 1'b1; i++) begin
      src_valid = pat[i[1:0]];
      pix_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("f6.done", 64'(done), 64'(1));
    checkFrame("f6");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_scheduler.md
CELL_SCHEDULER -- requirements
Module: cell_scheduler

Interface
REQ-001 SHALL have parameter CELL_DEPTH, default 72, width of one cell operand (3x3 window of 8-bit pixels).
REQ-002 SHALL have parameter OPCODE_WIDTH, default 4, width of the cell-processor opcode.
REQ-003 SHALL have parameter USER_WIDTH, default 8, width of the user-input operand.
REQ-004 SHALL have parameter PIXEL_WIDTH, default 8, width of one processed pixel.
REQ-005 SHALL have parameter PROC_LATENCY, default 2, fixed cycles from operand issue to valid proc_pixel (>=1).
REQ-006 SHALL have parameter NUM_CELLS, default 4096, cells per frame.
REQ-007 SHALL have derived constant FIFO_DEPTH = PROC_LATENCY+2, result FIFO entries.
REQ-008 SHALL have one clock and an asynchronous active-low reset; ports follow.
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 rst  input  1  asynchronous active-low reset.
REQ-011 start  input  1  frame start pulse.
REQ-012 abort  input  1  cancel current frame.
REQ-013 cfg_opcode  input  OPCODE_WIDTH  frame opcode.
REQ-014 cfg_user  input  USER_WIDTH  frame user input.
REQ-015 src_valid / src_ready  input / output  1 / 1  cell-source handshake.
REQ-016 src_cellA, src_cellB  input  CELL_DEPTH each  operand cells.
REQ-017 proc_cellA, proc_cellB  output  CELL_DEPTH each  to cell processor.
REQ-018 proc_userInput / proc_opcode  output  USER_WIDTH / OPCODE_WIDTH  to cell processor.
REQ-019 proc_valid  output  1  issue strobe; proc_pixel  input  PIXEL_WIDTH  processor result.
REQ-020 pix_valid / pix_ready  output / input  1 / 1  result handshake; pix_data  output  PIXEL_WIDTH; pix_last  output  1.
REQ-021 busy  output  1  frame in progress; done  output  1  one-cycle frame completion pulse.

Function
REQ-022 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE + start: latch cfg_opcode/cfg_user into proc_opcode/proc_userInput; clear issue/output counters; go RUN; busy=1 from next cycle.
REQ-024 start outside IDLE SHALL be ignored; proc_opcode/proc_userInput SHALL stay constant for the whole frame regardless of cfg_* changes.
REQ-025 src_ready SHALL be 1 only in RUN with issued<NUM_CELLS and (in-flight + FIFO occupancy) < FIFO_DEPTH.
REQ-026 Transfer (src_valid&src_ready) at cycle T: proc_cellA/B registered and proc_valid=1 in cycle T+1 only; proc_cellA/B hold last value otherwise.
REQ-027 proc_pixel SHALL be captured in cycle T+1+PROC_LATENCY (valid shift register of length PROC_LATENCY) and pushed to FIFO; earliest pix_valid is T+2+PROC_LATENCY.
REQ-028 pix_valid = FIFO non-empty; pop on pix_valid&pix_ready; pix_data is FIFO head; pix_data/pix_valid SHALL NOT change while pix_valid&!pix_ready.
REQ-029 pix_last SHALL be 1 exactly while the head is pixel index NUM_CELLS-1.
REQ-030 Simultaneous push and pop SHALL leave occupancy unchanged; credit rule REQ-025 guarantees no overflow; pop when empty impossible.
REQ-031 issued reaching NUM_CELLS SHALL move RUN->DRAIN; DRAIN after NUM_CELLS pixels accepted ->DONE; DONE lasts one cycle with done=1, busy=0, then IDLE.
REQ-032 Pixel order SHALL equal cell transfer order; counters sized clog2(NUM_CELLS+1), no wrap.
REQ-033 abort in RUN/DRAIN: next cycle IDLE, FIFO and shift register flushed, counters zeroed, pix_valid=0, src_ready=0, done never asserted; abort and start together in IDLE: abort wins, stays IDLE.

Reset
REQ-034 rst=0 SHALL immediately, without clock edge, force IDLE and all outputs 0 (proc_*, pix_*, src_ready, busy, done), flush FIFO and shift register; rst mid-frame discards the frame.
REQ-035 First action after rst release SHALL require a new start.

Verification (NUM_CELLS=4, PROC_LATENCY=2, FIFO_DEPTH=4)
REQ-036 start, opcode=3, src_valid=1, pix_ready=1 -> 4 proc_valid pulses with proc_opcode=3, first pix_valid 4 cycles after first transfer, pix_last on 4th pixel, done pulse one cycle after 4th accept, busy=0.
REQ-037 pix_ready=0 throughout -> exactly 4 transfers then src_ready=0; release pix_ready -> 4 pixels in order, none lost or duplicated.
REQ-038 abort after 2 transfers -> next cycle busy=0, pix_valid=0, src_ready=0, no done; following start runs a full clean frame.
REQ-039 start pulse and cfg_opcode=7 mid-frame (frame opcode 3) -> ignored, proc_opcode stays 3.
REQ-040 rst low mid-DRAIN between clock edges -> all outputs 0 before next edge; state IDLE after release.
REQ-041 src_valid toggling 1,0,0,1 with random pix_ready -> pixel order matches cell order, pix_last on 4th only.
